// File: rtl/cube_bus_capture.sv
// Observer for the LED cube drive bus. It models the row latches and layer
// enables, rebuilds the 8x8x8 frame and serves a snapshot as a framed byte
// stream: a header byte, then 64 bytes ordered layer-major.
module cube_bus_capture #(
  parameter logic [7:0]  HEADER_BYTE = 8'hA5,
  parameter int unsigned FRAME_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             layers_in,
  input  logic [7:0]             latches_in,
  input  logic [7:0]             data_in,
  input  logic                   rd_req,
  input  logic                   err_clr,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   busy,
  output logic                   frame_done,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic                   layer_err
);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_e;

  state_e                 state_q, state_d;
  logic [5:0]             k_q, k_d;
  logic [7:0]             tx_data_q, tx_data_d;
  logic [7:0]             latches_prev_q, layers_prev_q;
  logic [7:0]             row_q  [8];
  logic [7:0]             mem_q  [8][8];
  logic [7:0]             snap_q [8][8];
  logic [7:0]             seen_q;
  logic                   err_q, frame_done_q;
  logic [FRAME_CNT_W-1:0] frame_count_q;

  logic       layer_any, layer_onehot, layer_multi;
  logic       commit, complete, busy_w;
  logic [2:0] idx;
  logic [7:0] seen_set;
  logic [5:0] k_next;

  assign layer_any    = (layers_in != 8'd0);
  assign layer_onehot = layer_any && ((layers_in & (layers_in - 8'd1)) == 8'd0);
  assign layer_multi  = layer_any && !layer_onehot;
  // A layer only commits when the enable changes, so a held layer does not
  // keep rewriting memory.
  assign commit       = layer_onehot && (layers_in != layers_prev_q);
  assign seen_set     = seen_q | (8'd1 << idx);
  assign complete     = commit && (seen_set == 8'hFF);
  assign busy_w       = (state_q != IDLE);
  assign k_next       = k_q + 6'd1;

  // Encode the index of the enabled layer (meaningful only when one-hot).
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (layers_in[i]) idx = 3'(i);
    end
  end

  // Edge-detect history and row latches: a rising latch clock captures data_in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latches_prev_q <= 8'd0;
      layers_prev_q  <= 8'd0;
      for (int i = 0; i < 8; i++) row_q[i] <= 8'd0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
      latches_prev_q <= latches_in;
      layers_prev_q  <= layers_in;
      for (int i = 0; i < 8; i++) begin
        if (latches_in[i] && !latches_prev_q[i]) row_q[i] <= data_in;
      end
    end
  end

  // Layer memory and readback snapshot; the snapshot freezes while a packet is out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: these arrays are reset because a readback straight after reset must return zeros.
      for (int l = 0; l < 8; l++) begin
        for (int r = 0; r < 8; r++) begin
          mem_q[l][r]  <= 8'd0;
          snap_q[l][r] <= 8'd0;
        end
      end
    end else begin
      if (commit) begin
        for (int r = 0; r < 8; r++) mem_q[idx][r] <= row_q[r];
      end
      if (complete && !busy_w) begin
        for (int l = 0; l < 8; l++) begin
          for (int r = 0; r < 8; r++) begin
            snap_q[l][r] <= (3'(l) == idx) ? row_q[r] : mem_q[l][r];
          end
        end
      end
    end
  end

  // Frame bookkeeping and the sticky multi-hot error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_q        <= 8'd0;
      err_q         <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      frame_done_q <= complete;
      if (complete) begin
        seen_q        <= 8'd0;
        frame_count_q <= frame_count_q + FRAME_CNT_W'(1);
      end else if (commit) begin
        seen_q <= seen_set;
      end
      if (layer_multi)  err_q <= 1'b1;
      else if (err_clr) err_q <= 1'b0;
    end
  end

  // Readback FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      k_q       <= 6'd0;
      tx_data_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      tx_data_q <= tx_data_d;
    end
  end

  // Readback FSM next state; tx_data only moves on an accept, so it holds under backpressure.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    tx_data_d = tx_data_q;
    case (state_q)
      IDLE: begin
        if (rd_req) begin
          state_d   = HDR;
          tx_data_d = HEADER_BYTE;
        end
      end
      HDR: begin
        if (tx_ready) begin
          state_d   = DATA;
          k_d       = 6'd0;
          tx_data_d = snap_q[0][0];
        end
      end
      DATA: begin
        if (tx_ready) begin
          if (k_q == 6'd63) begin
            state_d   = IDLE;
            k_d       = 6'd0;
            tx_data_d = 8'd0;
          end else begin
            k_d       = k_next;
            tx_data_d = snap_q[k_next[5:3]][k_next[2:0]];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_data     = tx_data_q;
  assign tx_valid    = busy_w;
  assign busy        = busy_w;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;
  assign layer_err   = err_q;

endmodule

// File: tb/tb_cube_bus_capture.sv
// Directed bench for cube_bus_capture: a behavioural model of rows, layers and
// snapshot feeds a byte queue at each readback request; bytes are popped and
// compared as the DUT presents them.
module tb_cube_bus_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  layers_in, latches_in, data_in;
  logic        rd_req, err_clr, tx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid, busy, frame_done, layer_err;
  logic [15:0] frame_count;

  cube_bus_capture #(.HEADER_BYTE(8'hA5), .FRAME_CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .layers_in(layers_in), .latches_in(latches_in), .data_in(data_in),
    .rd_req(rd_req), .err_clr(err_clr),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .frame_done(frame_done), .frame_count(frame_count),
    .layer_err(layer_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q [$];

  // Reference model of the observed cube state.
  logic [7:0] m_row  [8];
  logic [7:0] m_mem  [8][8];
  logic [7:0] m_snap [8][8];
  logic [7:0] m_seen;
  int         m_count;
  bit         m_busy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic model_reset();
    for (int l = 0; l < 8; l++) begin
      m_row[l] = 8'd0;
      for (int r = 0; r < 8; r++) begin
        m_mem[l][r]  = 8'd0;
        m_snap[l][r] = 8'd0;
      end
    end
    m_seen  = 8'd0;
    m_count = 0;
  endtask

  task automatic model_commit(input int l, output bit done);
    for (int r = 0; r < 8; r++) m_mem[l][r] = m_row[r];
    m_seen = m_seen | 8'(1 << l);
    done = 1'b0;
    if (m_seen == 8'hFF) begin
      done    = 1'b1;
      m_seen  = 8'd0;
      m_count = m_count + 1;
      if (!m_busy) begin
        for (int a = 0; a < 8; a++)
          for (int b = 0; b < 8; b++) m_snap[a][b] = m_mem[a][b];
      end
    end
  endtask

  task automatic latch_row(input int r, input logic [7:0] d);
    latches_in = 8'(1 << r);
    data_in    = d;
    m_row[r]   = d;
    step();
    latches_in = 8'd0;
    step();
  endtask

  task automatic enable_layer(input int l);
    bit done;
    layers_in = 8'(1 << l);
    model_commit(l, done);
    step();
    check($sformatf("frame_done_l%0d", l), frame_done, done);
    layers_in = 8'd0;
    step();
    check("frame_done_pulse_end", frame_done, 1'b0);
  endtask

  task automatic load_layer(input int l, input logic [7:0] base);
    for (int r = 0; r < 8; r++) latch_row(r, 8'(base + r));
    enable_layer(l);
  endtask

  // Runs one readback. Stalls tx_ready at byte stall_idx for stall_len cycles,
  // optionally committing layer 7 during the stall; abort_idx >= 0 pulls reset
  // at that byte.
  task automatic read_packet(input int stall_idx, input int stall_len,
                             input bit commit7, input int abort_idx);
    int bi, accepts, guard, stalls;
    bit done;
    logic [7:0] e;
    exp_q.push_back(8'hA5);
    for (int k = 0; k < 64; k++) exp_q.push_back(m_snap[k / 8][k % 8]);
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    m_busy = 1'b1;
    bi = 0; accepts = 0; guard = 0; stalls = 0;
    while (exp_q.size() > 0 && guard < 400) begin
      guard++;
      if (bi == abort_idx) begin
        rst_n = 1'b0;
        #1;
        check("abort_tx_valid", tx_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_frame_count", frame_count, 16'd0);
        check("abort_layer_err", layer_err, 1'b0);
        exp_q.delete();
        model_reset();
        tx_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        break;
      end
      if (bi == stall_idx && stalls < stall_len) begin
        tx_ready = 1'b0;
        if (commit7) begin
          layers_in = (stalls == 0) ? 8'h80 : 8'h00;
          if (stalls == 0) model_commit(7, done);
        end
        check("stall_valid", tx_valid, 1'b1);
        check($sformatf("stall_data_b%0d", bi), tx_data, exp_q[0]);
        stalls++;
        step();
        continue;
      end
      layers_in = 8'd0;
      tx_ready  = 1'b1;
      e = exp_q.pop_front();
      check("tx_valid", tx_valid, 1'b1);
      check($sformatf("byte_%0d", bi), tx_data, e);
      accepts++;
      bi++;
      step();
    end
    tx_ready  = 1'b0;
    layers_in = 8'd0;
    if (abort_idx < 0) begin
      check("packet_timeout", exp_q.size(), 0);
      check("accept_count", accepts, 65);
      check("end_tx_valid", tx_valid, 1'b0);
      check("end_busy", busy, 1'b0);
    end
    m_busy = 1'b0;
  endtask

  initial begin
    bit done;
    rst_n = 1'b0; layers_in = 8'd0; latches_in = 8'd0; data_in = 8'd0;
    rd_req = 1'b0; err_clr = 1'b0; tx_ready = 1'b0; m_busy = 1'b0;
    model_reset();
    #1;
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_tx_data", tx_data, 8'd0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_frame_count", frame_count, 16'd0);
    check("rst_layer_err", layer_err, 1'b0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Frame A: layer 0 rows 10..17, others zero; read back with a stall at k=3.
    load_layer(0, 8'h10);
    for (int l = 1; l < 8; l++) load_layer(l, 8'h00);
    check("frame_count_A", frame_count, 16'd1);
    read_packet(4, 5, 1'b0, -1);

    // Frame B: recommit, multi-hot, err_clr priority, latch/enable collision.
    load_layer(0, 8'h20);
    load_layer(1, 8'h28);
    load_layer(0, 8'h30);
    for (int r = 0; r < 8; r++) latch_row(r, 8'hEE);
    layers_in = 8'h03;
    step();
    check("multi_err_set", layer_err, 1'b1);
    layers_in = 8'h03; err_clr = 1'b1;
    step();
    check("multi_err_set_wins", layer_err, 1'b1);
    layers_in = 8'h00;
    step();
    check("multi_err_cleared", layer_err, 1'b0);
    err_clr = 1'b0;
    check("multi_no_frame", frame_count, 16'(m_count));
    for (int r = 0; r < 8; r++) latch_row(r, 8'(8'h40 + r));
    latch_row(0, 8'hAA);
    latches_in = 8'h01; data_in = 8'h55; layers_in = 8'h04;
    model_commit(2, done);
    m_row[0] = 8'h55;
    step();
    check("collide_frame_done", frame_done, done);
    latches_in = 8'd0; layers_in = 8'd0;
    step();
    for (int r = 1; r < 8; r++) latch_row(r, 8'(8'h50 + r));
    enable_layer(3);
    for (int l = 4; l < 8; l++) load_layer(l, 8'(8'h60 + 8 * (l - 4)));
    check("frame_count_B", frame_count, 16'd2);
    read_packet(-1, 0, 1'b0, -1);

    // Frame C completes while a packet is in flight: packet keeps frame B.
    for (int l = 0; l < 7; l++) load_layer(l, 8'(8'h80 + 8 * l));
    for (int r = 0; r < 8; r++) latch_row(r, 8'(8'hB8 + r));
    read_packet(10, 4, 1'b1, -1);
    check("frame_count_C", frame_count, 16'd3);
    read_packet(-1, 0, 1'b0, -1);
    for (int l = 0; l < 8; l++) load_layer(l, 8'(16 * l + 1));
    check("frame_count_D", frame_count, 16'd4);
    read_packet(-1, 0, 1'b0, -1);

    // Reset mid-packet at k=20, with layer_err set beforehand.
    layers_in = 8'h81;
    step();
    layers_in = 8'h00;
    check("pre_abort_err", layer_err, 1'b1);
    read_packet(-1, 0, 1'b0, 21);
    read_packet(-1, 0, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cube_bus_capture.md
Name: cube_bus_capture

Overview:
- Receiving end of the cube drive bus: observes the Layers/Latches/Data outputs of the LED cube driver, models the row latches and layer enables, and reconstructs the displayed 8x8x8 frame.
- The reconstructed frame is read back as a framed byte stream over a valid/ready port, for on-board self-check and host readback.
- Sits beside the cube driver at its outputs; it is a pure observer and never drives the cube.

Parameters:
- HEADER_BYTE, 8'hA5, first byte of every readback packet.
- FRAME_CNT_W, 16, width of the completed-frame counter.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; asynchronous, active-low.
- layers_in  input  8  layer enables from the driver (one-hot when valid).
- latches_in  input  8  row latch clocks from the driver.
- data_in  input  8  row data from the driver.
- rd_req  input  1  single-cycle request to start a readback packet.
- err_clr  input  1  clears layer_err.
- tx_data  output  8  readback byte.
- tx_valid  output  1  tx_data is valid.
- tx_ready  input  1  consumer accepts the byte when tx_valid is also high.
- busy  output  1  a readback packet is in progress.
- frame_done  output  1  one-cycle pulse when a full frame (all 8 layers) has been committed.
- frame_count  output  FRAME_CNT_W  number of completed frames; wraps to 0 after all-ones.
- layer_err  output  1  sticky flag: layers_in had more than one bit set.

Behaviour:
- Reset values, asynchronous: all outputs 0; tx_data 0; row_reg, layer_mem, snapshot, seen mask, prev registers and state all 0; state IDLE.
- Input edge detection: latches_prev and layers_prev are registered copies of the inputs, updated every clk.
- Latch capture: for each i with latches_in[i]=1 and latches_prev[i]=0, row_reg[i] <= data_in at that edge. Several simultaneous rising bits all capture the same data_in. A held-high latch does not recapture.
- Layer commit: when layers_in is one-hot and layers_in != layers_prev, with idx = index of the set bit:
  - layer_mem[idx] <= row_reg, using the values before this edge. A latch rising in the same cycle updates row_reg only.
  - seen[idx] <= 1.
- All-zero layers_in: no commit, no error.
- More than one bit set in layers_in: no commit; layer_err <= 1.
- layer_err clears on err_clr. If err_clr and a new multi-hot input occur in the same cycle, set wins.
- Frame completion: when a commit makes seen all-ones:
  - frame_done pulses high for the following cycle.
  - frame_count increments.
  - seen clears to 0.
  - snapshot <= layer_mem including this commit, only if busy=0. If busy=1 the snapshot is unchanged; frame_done and frame_count still update.
- Recommitting an already-seen layer before the frame completes overwrites layer_mem[idx] and does not advance completion.
- Readback FSM, IDLE -> HDR -> DATA -> IDLE:
  - IDLE: on rd_req=1, go to HDR. tx_valid=1, tx_data=HEADER_BYTE and busy=1 are registered, visible the cycle after rd_req.
  - HDR: when tx_valid&&tx_ready, go to DATA with byte index k=0.
  - DATA: tx_data = snapshot layer k/8, latch k%8, with k a 6-bit counter. Each accept increments k. The accept at k=63 returns to IDLE with tx_valid=0 and busy=0 on the next cycle.
- Packet length is 65 bytes.
- tx_data is held stable while tx_valid=1 and tx_ready=0.
- rd_req while busy=1 is ignored; it is not queued.
- tx_ready while tx_valid=0 has no effect.
- Capture and commit continue during readback. Only the snapshot copy is suppressed.
- Asynchronous reset mid-packet aborts the packet immediately: tx_valid=0, busy=0.

Test Plan:
- Capture one layer and read back:
  - Stimulus: raise latches_in bits 0..7 in turn with data_in=8'h10+i, then layers_in=8'h01.
  - Stimulus: load and enable layers 1..7 the same way with data 8'h00.
  - Required: frame_done pulses once; frame_count=1; rd_req yields A5,10,11,…,17, then 56 bytes of 00.
- Backpressure:
  - Stimulus: during readback, hold tx_ready=0 for 5 cycles at k=3.
  - Required: tx_data stays at byte 3 and tx_valid stays 1; exactly 65 accepts total.
- Multi-hot layers:
  - Stimulus: layers_in=8'h03.
  - Required: layer_err=1; no commit; seen unchanged. After err_clr, layer_err=0.
- Simultaneous latch rise and layer enable:
  - Stimulus: row_reg[0]=AA, then latches_in[0] rises with data_in=55 in the same cycle as layers_in=8'h04.
  - Required: layer_mem[2] row0=AA and row_reg[0]=55.
- Frame completes during readback:
  - Stimulus: complete a frame while busy=1.
  - Required: frame_count increments; the remaining packet bytes equal the old snapshot; the next packet shows the new frame only after the following completion.
- Reset mid-packet:
  - Stimulus: assert rst_n=0 at k=20.
  - Required: tx_valid, busy, frame_count and layer_err all 0 with no clock edge; a subsequent rd_req returns A5 then 64 bytes of 00.
